// File: rtl/conv_tap_multiplier.sv
// conv_tap_multiplier: holds 5 serially loaded weights and a 5-sample sliding
// window over the pixel stream; each time a full window advances it presents
// five registered unsigned tap products with a one-cycle Enable strobe.
module conv_tap_multiplier #(
    parameter int Bit_width = 8
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Weight_load,
    input  logic [Bit_width-1:0]     Weight_in,
    input  logic                     Data_valid,
    input  logic [Bit_width-1:0]     Data_in,
    output logic                     Data_ready,
    input  logic                     Flush,
    output logic [2*Bit_width-1:0]   Mul_result_0,
    output logic [2*Bit_width-1:0]   Mul_result_1,
    output logic [2*Bit_width-1:0]   Mul_result_2,
    output logic [2*Bit_width-1:0]   Mul_result_3,
    output logic [2*Bit_width-1:0]   Mul_result_4,
    output logic                     Enable
);

    localparam int PW = 2 * Bit_width;

    logic [Bit_width-1:0] weight_q [5];
    logic [Bit_width-1:0] weight_d [5];
    logic [Bit_width-1:0] win_q    [5];
    logic [Bit_width-1:0] win_d    [5];
    logic [PW-1:0]        mul_q    [5];
    logic [PW-1:0]        mul_d    [5];
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           fill_q, fill_d;
    logic                 wrdy_q, wrdy_d;
    logic                 pend_q, pend_d;
    logic                 en_q, en_d;
    logic                 accept_s;

    // Samples are only taken once all five weights are in place and no
    // weight beat or flush is clearing the window this cycle.
    assign Data_ready = wrdy_q & ~Weight_load & ~Flush;
    assign accept_s   = Data_valid & Data_ready;

    assign Mul_result_0 = mul_q[0];
    assign Mul_result_1 = mul_q[1];
    assign Mul_result_2 = mul_q[2];
    assign Mul_result_3 = mul_q[3];
    assign Mul_result_4 = mul_q[4];
    assign Enable       = en_q;

    // Next-state logic: weight loading, window shift/clear, product stage.
    always_comb begin
        weight_d = weight_q;
        win_d    = win_q;
        mul_d    = mul_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        wrdy_d   = wrdy_q;
        pend_d   = 1'b0;
        en_d     = 1'b0;

        // Product stage: a weight beat cancels the in-flight result, a flush
        // does not (it only affects later results).
        if (pend_q && !Weight_load) begin
            for (int k = 0; k < 5; k++) begin
                mul_d[k] = PW'(weight_q[k]) * PW'(win_q[k]);
            end
            en_d = 1'b1;
        end else begin
            en_d = 1'b0;
        end

        // Serial weight load; the set is complete on the beat writing Weight_4.
        if (Weight_load) begin
            for (int k = 0; k < 5; k++) begin
                if (cnt_q == 3'(k)) begin
                    weight_d[k] = Weight_in;
                end else begin
                    weight_d[k] = weight_q[k];
                end
            end
            if (cnt_q == 3'd0) begin
                wrdy_d = 1'b0;
            end else if (cnt_q == 3'd4) begin
                wrdy_d = 1'b1;
            end else begin
                wrdy_d = wrdy_q;
            end
            cnt_d = (cnt_q == 3'd4) ? 3'd0 : (cnt_q + 3'd1);
        end else begin
            cnt_d = cnt_q;
        end

        // Window: cleared by weight beats and flushes, shifted on accept.
        if (Weight_load || Flush) begin
            for (int k = 0; k < 5; k++) begin
                win_d[k] = '0;
            end
            fill_d = 3'd0;
            pend_d = 1'b0;
        end else if (accept_s) begin
            win_d[0] = Data_in;
            for (int k = 1; k < 5; k++) begin
                win_d[k] = win_q[k-1];
            end
            fill_d = (fill_q == 3'd5) ? 3'd5 : (fill_q + 3'd1);
            pend_d = (fill_d == 3'd5);
        end else begin
            pend_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < 5; k++) begin
                weight_q[k] <= '0;
                win_q[k]    <= '0;
                mul_q[k]    <= '0;
            end
            cnt_q  <= 3'd0;
            fill_q <= 3'd0;
            wrdy_q <= 1'b0;
            pend_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            weight_q <= weight_d;
            win_q    <= win_d;
            mul_q    <= mul_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            wrdy_q   <= wrdy_d;
            pend_q   <= pend_d;
            en_q     <= en_d;
        end
    end

endmodule
